// File: rtl/gcd_rr_scheduler.sv
// ---------------------------------------------------------------------------
// GcdRrScheduler
// Shares a single multi-cycle GCD unit between N requesters. A round-robin
// arbiter picks one pending request while the scheduler is idle, forwards
// the operands to the GCD unit and returns the result on a response channel
// tagged with the requester index. Requests with a zero operand are answered
// directly without using the GCD unit, and a GCD computation that exceeds
// TMO wait cycles is aborted and answered with an error response.
//
// Ports
//    clk_i            rising-edge clock
//    reset_i          asynchronous active-high reset
//    req_valid_i      per-requester request valid (N bits)
//    req_a_i/req_b_i  packed operands, requester i in slice [i*W +: W]
//    req_ready_o      one-hot grant, only asserted while idle
//    gcd_start_o      one-cycle start pulse to the GCD controller
//    gcd_inA_o/inB_o  operands presented to the GCD datapath
//    gcd_result_rdy_i done/idle flag from the GCD controller
//    gcd_result_i     result from the GCD datapath
//    gcd_abort_o      one-cycle reset pulse to the GCD unit on timeout
//    rsp_valid_o      response valid, held until rsp_ready_i
//    rsp_id_o         index of the requester being answered
//    rsp_data_o       GCD result (or zero on timeout)
//    rsp_err_o        set when the response is a timeout
//    rsp_ready_i      response consumer ready
// ---------------------------------------------------------------------------
module gcd_rr_scheduler #(
   parameter int W   = 8,
   parameter int N   = 4,
   parameter int TMO = 255
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [N-1:0]           req_valid_i,
   input  logic [N*W-1:0]         req_a_i,
   input  logic [N*W-1:0]         req_b_i,
   output logic [N-1:0]           req_ready_o,
   output logic                   gcd_start_o,
   output logic [W-1:0]           gcd_inA_o,
   output logic [W-1:0]           gcd_inB_o,
   input  logic                   gcd_result_rdy_i,
   input  logic [W-1:0]           gcd_result_i,
   output logic                   gcd_abort_o,
   output logic                   rsp_valid_o,
   output logic [$clog2(N)-1:0]   rsp_id_o,
   output logic [W-1:0]           rsp_data_o,
   output logic                   rsp_err_o,
   input  logic                   rsp_ready_i
);

   localparam int IW = $clog2(N);
   localparam int CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ABORT,
      RESP
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   inA_q, inA_d;
   logic [W-1:0]   inB_q, inB_d;
   logic [IW-1:0]  rspId_q, rspId_d;
   logic [W-1:0]   rspData_q, rspData_d;
   logic           rspErr_q, rspErr_d;

   logic           grantFound;
   logic [IW-1:0]  grantIdx;
   logic [IW-1:0]  candIdx;
   logic [N-1:0]   grantVec;
   logic [W-1:0]   selA;
   logic [W-1:0]   selB;

   // Round-robin search: scan from the requester after the last winner and
   // wrap around, so the last winner has the lowest priority next time.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      candIdx    = '0;
      grantVec   = '0;
      for (int k = 1; k <= N; k++) begin
         candIdx = IW'((int'(ptr_q) + k) % N);
         if (!grantFound && req_valid_i[candIdx]) begin
            grantFound = 1'b1;
            grantIdx   = candIdx;
         end
      end
      if (grantFound) begin
         grantVec[grantIdx] = 1'b1;
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      selA = '0;
      selB = '0;
      for (int i = 0; i < N; i++) begin
         if (grantIdx == IW'(i)) begin
            selA = req_a_i[i*W +: W];
            selB = req_b_i[i*W +: W];
         end
      end
   end

   // Next-state logic. The GCD-facing operand registers are only loaded for
   // requests that really use the GCD unit, so a zero-bypass request leaves
   // the GCD operand bus untouched. Completion needs cnt >= 1 because the
   // ready flag seen in the first wait cycle may still be left over from the
   // previous job; completion is tested before the timeout so it wins a tie.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      inA_d     = inA_q;
      inB_d     = inB_q;
      rspId_d   = rspId_q;
      rspData_d = rspData_q;
      rspErr_d  = rspErr_q;
      case (state_q)
         IDLE: begin
            if (grantFound) begin
               ptr_d   = grantIdx;
               rspId_d = grantIdx;
               if (selA == '0 || selB == '0) begin
                  rspData_d = selA | selB;
                  rspErr_d  = 1'b0;
                  state_d   = RESP;
               end else begin
                  inA_d   = selA;
                  inB_d   = selB;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (gcd_result_rdy_i && cnt_q != '0) begin
               rspData_d = gcd_result_i;
               rspErr_d  = 1'b0;
               state_d   = RESP;
            end else if (cnt_q == CW'(TMO)) begin
               state_d = ABORT;
            end
         end
         ABORT: begin
            rspData_d = '0;
            rspErr_d  = 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. The pointer resets to N-1 so that the
   // first search after reset starts at requester 0.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         ptr_q     <= IW'(N - 1);
         cnt_q     <= '0;
         inA_q     <= '0;
         inB_q     <= '0;
         rspId_q   <= '0;
         rspData_q <= '0;
         rspErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         inA_q     <= inA_d;
         inB_q     <= inB_d;
         rspId_q   <= rspId_d;
         rspData_q <= rspData_d;
         rspErr_q  <= rspErr_d;
      end
   end

   // The grant is combinational from the request inputs, so it is gated with
   // reset to drop immediately rather than waiting for the state register.
   assign req_ready_o = (state_q == IDLE && !reset_i) ? grantVec : '0;
   assign gcd_start_o = (state_q == ISSUE);
   assign gcd_abort_o = (state_q == ABORT);
   assign rsp_valid_o = (state_q == RESP);
   assign gcd_inA_o   = inA_q;
   assign gcd_inB_o   = inB_q;
   assign rsp_id_o    = rspId_q;
   assign rsp_data_o  = rspData_q;
   assign rsp_err_o   = rspErr_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// ---------------------------------------------------------------------------
// TbGcdRrScheduler
// Drives requests into the scheduler, emulates a multi-cycle GCD unit and
// matches every response against a queue of expected responses filled when
// the requests are applied.
// ---------------------------------------------------------------------------
module tb_gcd_rr_scheduler;

   localparam int W = 8;
   localparam int N = 4;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  reqValid;
   logic [N*W-1:0] reqA;
   logic [N*W-1:0] reqB;
   logic [N-1:0]  reqReady;
   logic          gcdStart;
   logic [W-1:0]  gcdInA;
   logic [W-1:0]  gcdInB;
   logic          gcdResultRdy = 1'b1;
   logic [W-1:0]  gcdResult = '0;
   logic          gcdAbort;
   logic          rspValid;
   logic [1:0]    rspId;
   logic [W-1:0]  rspData;
   logic          rspErr;
   logic          rspReady;

   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];

   int   cyc = 0;
   int   accCyc = 0;
   int   accCount = 0;
   int   lastGrant = -1;
   int   rspRiseCyc = 0;
   int   startSeen = 0;
   int   abortSeen = 0;
   int   xferCount = 0;
   logic prevRspValid = 1'b0;
   logic [W-1:0] startA = '0;
   logic [W-1:0] startB = '0;

   int   modelDelay = 6;
   logic neverReady = 1'b0;
   logic modelStale = 1'b0;
   logic modelBusy = 1'b0;
   int   modelLat = 0;
   logic [W-1:0] mA = '0;
   logic [W-1:0] mB = '0;

   gcd_rr_scheduler #(.W(W), .N(N), .TMO(16)) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .req_valid_i      (reqValid),
      .req_a_i          (reqA),
      .req_b_i          (reqB),
      .req_ready_o      (reqReady),
      .gcd_start_o      (gcdStart),
      .gcd_inA_o        (gcdInA),
      .gcd_inB_o        (gcdInB),
      .gcd_result_rdy_i (gcdResultRdy),
      .gcd_result_i     (gcdResult),
      .gcd_abort_o      (gcdAbort),
      .rsp_valid_o      (rspValid),
      .rsp_id_o         (rspId),
      .rsp_data_o       (rspData),
      .rsp_err_o        (rspErr),
      .rsp_ready_i      (rspReady)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Euclid reference used by the GCD model and by the expectations.
   function automatic logic [7:0] gcdRef(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // GCD unit model: busy for modelDelay cycles after a start, the ready flag
   // doubles as the idle flag. With modelStale the ready flag lingers for one
   // cycle after the start, with neverReady the job never finishes.
   always @(posedge clk) begin
      if (gcdAbort) begin
         modelBusy    <= 1'b0;
         gcdResultRdy <= 1'b1;
      end else if (gcdStart) begin
         modelBusy    <= 1'b1;
         modelLat     <= modelDelay;
         mA           <= gcdInA;
         mB           <= gcdInB;
         gcdResultRdy <= modelStale;
      end else if (modelBusy && !neverReady) begin
         if (modelLat <= 1) begin
            modelBusy    <= 1'b0;
            gcdResultRdy <= 1'b1;
            gcdResult    <= gcdRef(mA, mB);
         end else begin
            modelLat     <= modelLat - 1;
            gcdResultRdy <= 1'b0;
         end
      end else if (modelBusy) begin
         gcdResultRdy <= 1'b0;
      end
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Raise a request and queue the response it must produce.
   task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      reqA[idx*W +: W] = a;
      reqB[idx*W +: W] = b;
      reqValid[idx]    = 1'b1;
      e.id = idx;
      if (a == 0 || b == 0) begin
         e.data = a | b;
         e.err  = 1'b0;
      end else if (neverReady) begin
         e.data = 8'h00;
         e.err  = 1'b1;
      end else begin
         e.data = gcdRef(a, b);
         e.err  = 1'b0;
      end
      expQ.push_back(e);
   endtask

   // One clock cycle: observe at the falling edge, advance past the rising
   // edge, then drop the valid of any requester that was just granted.
   task automatic tick();
      logic [N-1:0] acc;
      exp_t e;
      @(negedge clk);
      acc = reqValid & reqReady;
      if (acc != 0) begin
         accCyc = cyc;
         accCount++;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) lastGrant = i;
         end
      end
      if (gcdStart) begin
         startSeen++;
         startA = gcdInA;
         startB = gcdInB;
      end
      if (gcdAbort) abortSeen++;
      if (rspValid && !prevRspValid) rspRiseCyc = cyc;
      prevRspValid = rspValid;
      if (rspValid && rspReady) begin
         xferCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("rsp_id", 32'(rspId), 32'(e.id));
            checkOutput("rsp_data", 32'(rspData), 32'(e.data));
            checkOutput("rsp_err", 32'(rspErr), 32'(e.err));
         end
      end
      cyc++;
      @(posedge clk);
      #1;
      reqValid = reqValid & ~acc;
   endtask

   task automatic waitDrain(input int limit);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < limit) begin
         tick();
         n++;
      end
      checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int s0;
      int a0;
      int x0;
      int n;

      reset    = 1'b1;
      rspReady = 1'b1;
      reqValid = '1;
      reqA     = '0;
      reqB     = '0;
      #2;
      checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
      checkOutput("rst_outputs", 32'({gcdStart, gcdAbort, rspValid, rspErr, rspId, rspData}), 32'd0);
      checkOutput("rst_gcd_in", 32'({gcdInA, gcdInB}), 32'd0);
      reqValid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single request, GCD ready after 6 cycles.
      $display("[TB] single request");
      s0 = startSeen;
      applyStimulus(0, 8'd30, 8'd20);
      waitDrain(60);
      checkOutput("single_start_cycles", 32'(startSeen - s0), 32'd1);
      checkOutput("single_inA", 32'(startA), 32'd30);
      checkOutput("single_inB", 32'(startB), 32'd20);
      checkOutput("single_latency", 32'(rspRiseCyc - accCyc), 32'd9);

      // Fairness from reset, with a stale ready flag after each start.
      $display("[TB] fairness");
      doReset();
      modelStale = 1'b1;
      applyStimulus(0, 8'd12, 8'd8);
      applyStimulus(1, 8'd27, 8'd18);
      applyStimulus(2, 8'd35, 8'd21);
      applyStimulus(3, 8'd64, 8'd48);
      waitDrain(200);
      applyStimulus(0, 8'd100, 8'd75);
      applyStimulus(2, 8'd81, 8'd54);
      waitDrain(100);
      modelStale = 1'b0;

      // Zero bypass.
      $display("[TB] bypass");
      s0 = startSeen;
      applyStimulus(1, 8'd0, 8'd45);
      waitDrain(20);
      checkOutput("bypass_latency", 32'(rspRiseCyc - accCyc), 32'd1);
      applyStimulus(3, 8'd0, 8'd0);
      waitDrain(20);
      checkOutput("bypass_no_start", 32'(startSeen - s0), 32'd0);

      // Timeout with a GCD unit that never finishes.
      $display("[TB] timeout");
      neverReady = 1'b1;
      s0 = abortSeen;
      applyStimulus(0, 8'd7, 8'd21);
      waitDrain(100);
      checkOutput("timeout_abort_cycles", 32'(abortSeen - s0), 32'd1);
      checkOutput("timeout_latency", 32'(rspRiseCyc - accCyc), 32'd20);
      neverReady = 1'b0;

      // Backpressure on the response channel.
      $display("[TB] backpressure");
      rspReady = 1'b0;
      applyStimulus(1, 8'd12, 8'd18);
      applyStimulus(3, 8'd9, 8'd6);
      n = 0;
      while (!rspValid && n < 50) begin
         tick();
         n++;
      end
      checkOutput("bp_rsp_valid", 32'(rspValid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bp_hold_valid", 32'(rspValid), 32'd1);
         checkOutput("bp_hold_id", 32'(rspId), 32'd1);
         checkOutput("bp_hold_data", 32'(rspData), 32'd6);
         checkOutput("bp_hold_err", 32'(rspErr), 32'd0);
         checkOutput("bp_req_ready", 32'(reqReady), 32'd0);
      end
      x0 = xferCount;
      rspReady = 1'b1;
      tick();
      tick();
      tick();
      rspReady = 1'b0;
      checkOutput("bp_transfers", 32'(xferCount - x0), 32'd1);
      rspReady = 1'b1;
      waitDrain(60);

      // Reset while waiting on the GCD unit.
      $display("[TB] reset in wait");
      a0 = accCount;
      applyStimulus(2, 8'd48, 8'd36);
      n = 0;
      while (accCount == a0 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("rw_accepted", 32'(accCount - a0), 32'd1);
      tick();
      tick();
      checkOutput("rw_inA_held", 32'(gcdInA), 32'd48);
      #1;
      reset = 1'b1;
      expQ.delete();
      applyStimulus(0, 8'd15, 8'd10);
      applyStimulus(1, 8'd14, 8'd21);
      applyStimulus(2, 8'd22, 8'd33);
      applyStimulus(3, 8'd50, 8'd0);
      #1;
      checkOutput("rw_req_ready", 32'(reqReady), 32'd0);
      checkOutput("rw_outputs", 32'({gcdStart, gcdAbort, rspValid, rspErr, rspId, rspData}), 32'd0);
      checkOutput("rw_gcd_in", 32'({gcdInA, gcdInB}), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      a0 = accCount;
      n = 0;
      while (accCount == a0 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("rw_first_grant", 32'(lastGrant), 32'd0);
      waitDrain(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcd_rr_scheduler.md
GCD_RR_SCHEDULER -- requirements
Module: gcd_rr_scheduler

Interface
REQ-001 Parameter W SHALL default to 8; it sets the operand and result width.
REQ-002 Parameter N SHALL default to 4; it sets the requester count, and N>=2.
REQ-003 Parameter TMO SHALL default to 255; it sets the WAIT timeout in cycles.
REQ-004 clk  in  1  SHALL be the rising-edge clock; the block has only this clock.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 req_valid  in  N  SHALL carry the per-requester request valid.
REQ-007 req_a  in  N*W  SHALL carry operand A; requester i uses slice [i*W +: W].
REQ-008 req_b  in  N*W  SHALL carry operand B with the same slicing.
REQ-009 req_ready  out  N  SHALL be the one-hot acceptance; at most one bit is set.
REQ-010 gcd_start  out  1  SHALL be the start pulse to the GCD controller.
REQ-011 gcd_inA, gcd_inB  out  W each  SHALL carry the operands to the GCD datapath.
REQ-012 gcd_result_rdy  in  1  SHALL be the done/idle flag from the GCD controller.
REQ-013 gcd_result  in  W  SHALL be the result from the GCD datapath.
REQ-014 gcd_abort  out  1  SHALL be a reset pulse to the GCD unit on timeout.
REQ-015 rsp_valid, rsp_id (clog2 N), rsp_data (W), rsp_err (1)  out  SHALL form the response channel.
REQ-016 rsp_ready  in  1  SHALL be the response consumer ready.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, ABORT and RESP.
REQ-018 Arbitration:
- Only in IDLE, req_ready SHALL be asserted combinationally for the round-robin winner among req_valid.
- The search starts at ptr+1 and wraps modulo N.
- req_ready SHALL be all-zero in any other state.
REQ-019 On req_valid[g]&req_ready[g] (accept), the block SHALL:
- latch req_a/req_b slice g into op_a/op_b;
- latch g into rsp_id;
- set ptr<=g.
REQ-020 Zero bypass: if the accepted op_a==0 or op_b==0, the next state SHALL be RESP, with:
- rsp_data=op_a|op_b;
- rsp_err=0;
- gcd_start never asserted.
REQ-021 Otherwise the next state SHALL be ISSUE; ISSUE SHALL last exactly one cycle with gcd_start=1, then go to WAIT.
REQ-022 gcd_inA/gcd_inB SHALL equal op_a/op_b from ISSUE through the WAIT exit cycle, and SHALL hold their last value elsewhere.
REQ-023 WAIT counter:
- cnt SHALL be cleared on WAIT entry and increment every WAIT cycle.
- Completion SHALL be gcd_result_rdy=1 with cnt>=1, which ignores a stale ready flag in the first WAIT cycle.
REQ-024 On completion the block SHALL capture gcd_result into rsp_data, set rsp_err=0 and go to RESP.
REQ-025 If cnt==TMO without completion, the block SHALL go to ABORT.
REQ-026 If completion and cnt==TMO occur in the same cycle, completion SHALL win.
REQ-027 ABORT SHALL last one cycle with gcd_abort=1, set rsp_data=0 and rsp_err=1, then go to RESP.
REQ-028 In RESP:
- rsp_valid SHALL be 1, and rsp_id/rsp_data/rsp_err SHALL stay stable until rsp_valid&rsp_ready.
- The block SHALL then return to IDLE; the earliest next accept is the following cycle.
REQ-029 Latency: rsp_valid SHALL rise 1 cycle after accept for a bypass, and (ISSUE + WAIT cycles + 1) after accept otherwise.
REQ-030 A requester that drops req_valid while not granted SHALL have no effect; a granted request is never cancelled.

Reset
REQ-031 While reset=1, the block SHALL force these outputs immediately, independent of clk: req_ready=0, gcd_start=0, gcd_inA=gcd_inB=0, gcd_abort=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
REQ-032 While reset=1, the block SHALL set the FSM to IDLE, ptr=N-1 and cnt=0.
REQ-033 Reset mid-operation SHALL discard the in-flight request with no response generated.

Verification
REQ-034 Single request: requester 0 with a=30, b=20, and the GCD model ready after 6 cycles -> gcd_start is high for one cycle with inA=30/inB=20, then rsp_id=0, rsp_data=10, rsp_err=0.
REQ-035 Fairness: all four requesters valid from reset -> grants go 0,1,2,3; requesters 0 and 2 re-requesting after 3 -> grants go 0 then 2.
REQ-036 Bypass: a=0, b=45 -> rsp_data=45 one cycle after accept, with no gcd_start; a=0, b=0 -> rsp_data=0.
REQ-037 Timeout: TMO=16 and the model never ready -> a single gcd_abort pulse, then rsp_err=1 and rsp_data=0.
REQ-038 Backpressure: rsp_ready low for 10 cycles -> rsp fields stay stable and req_ready stays all-zero; the 3-cycle pulse on rsp_ready completes exactly one transfer.
REQ-039 Reset asserted in WAIT -> outputs reach their reset values without a clock edge, no response follows release, and the next grant goes to requester 0.
